// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexed anode scan for an N-digit seven-segment display.
// Each digit slot shows its nibble and then blanks all anodes for a
// dead-time to suppress ghosting. Digit values arrive through a
// valid/ready port into a pending buffer. The pending buffer is promoted
// to the display register only at the end of a frame, so a frame never
// mixes old and new data.
module display_scan_controller #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int REFRESH_HZ    = 1000,
    parameter int N_DIGITS      = 4,
    parameter int BLANK_CYCLES  = 1000,
    parameter bit ANODE_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_data,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [1:0]            scan_idx,
    output logic [3:0]            scan_digit,
    output logic [N_DIGITS-1:0]   anodo,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int DWELL    = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int SHOW_LEN = DWELL - BLANK_CYCLES;
    localparam int CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(SHOW_LEN - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [1:0]          IDX_LAST   = 2'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_OFF  = ANODE_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    generate
        if ((DWELL <= BLANK_CYCLES) || (BLANK_CYCLES < 1) || (N_DIGITS < 1) || (N_DIGITS > 4)) begin : g_param_check
            $error("display_scan_controller: need DWELL > BLANK_CYCLES >= 1 and 1 <= N_DIGITS <= 4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [1:0]            idx_r, idx_s;
    logic                  prime_r, prime_s;      // 1 during the post-reset blank, which does not advance the scan
    logic                  en_r, en_s;            // enable of the current slot, latched on entry to SHOW
    logic [4*N_DIGITS-1:0] disp_r, disp_s;
    logic [4*N_DIGITS-1:0] pend_r, pend_s;
    logic                  pend_vld_r, pend_vld_s;
    logic                  frame_last_s;
    logic                  accept_s;

    logic [N_DIGITS-1:0]   onehot_s;
    logic [N_DIGITS-1:0]   anodo_s;
    logic                  lit_s;
    logic                  blank_s;
    logic [3:0]            scan_digit_s;
    logic                  frame_done_s;
    logic                  ready_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_BLANK;
            cnt_r      <= {CNT_W{1'b0}};
            idx_r      <= 2'd0;
            prime_r    <= 1'b1;
            en_r       <= 1'b0;
            disp_r     <= {(4*N_DIGITS){1'b0}};
            pend_r     <= {(4*N_DIGITS){1'b0}};
            pend_vld_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            prime_r    <= prime_s;
            en_r       <= en_s;
            disp_r     <= disp_s;
            pend_r     <= pend_s;
            pend_vld_r <= pend_vld_s;
        end
    end

    // Next-state logic: slot timing, scan index, enable latch and load buffering
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        idx_s      = idx_r;
        prime_s    = prime_r;
        en_s       = en_r;
        disp_s     = disp_r;
        pend_s     = pend_r;
        pend_vld_s = pend_vld_r;

        case (state_r)
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_SHOW;
                    cnt_s   = {CNT_W{1'b0}};
                    prime_s = 1'b0;
                    if (prime_r) begin
                        idx_s = idx_r;
                    end else if (idx_r == IDX_LAST) begin
                        idx_s = 2'd0;
                    end else begin
                        idx_s = idx_r + 2'd1;
                    end
                    en_s = digit_en[idx_s];
                end else begin
                    state_s = ST_BLANK;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        // Last blank cycle of the last digit closes the frame
        frame_last_s = (state_r == ST_BLANK) && (cnt_r == BLANK_LAST) &&
                       (idx_r == IDX_LAST) && !prime_r;
        accept_s     = load_valid && load_ready;

        // Acceptance needs an empty pending buffer, so it never coincides with a promotion
        if (frame_last_s && pend_vld_r) begin
            disp_s     = pend_r;
            pend_vld_s = 1'b0;
        end else if (accept_s) begin
            pend_s     = load_data;
            pend_vld_s = 1'b1;
        end else begin
            pend_vld_s = pend_vld_r;
        end
    end

    // Output decode from the next state so outputs register in step with the FSM
    always_comb begin
        onehot_s = {N_DIGITS{1'b0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            onehot_s[i] = (idx_s == 2'(i));
        end

        lit_s = (state_s == ST_SHOW) && en_s;
        if (lit_s) begin
            anodo_s = ANODE_ACT_LOW ? ~onehot_s : onehot_s;
        end else begin
            anodo_s = ANODE_OFF;
        end

        blank_s      = !lit_s;
        scan_digit_s = disp_s[{idx_s, 2'b00} +: 4];
        frame_done_s = (state_s == ST_BLANK) && (cnt_s == BLANK_LAST) &&
                       (idx_s == IDX_LAST) && !prime_s;
        ready_s      = !pend_vld_s;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodo      <= ANODE_OFF;
            blank      <= 1'b1;
            scan_digit <= 4'd0;
            scan_idx   <= 2'd0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            anodo      <= anodo_s;
            blank      <= blank_s;
            scan_digit <= scan_digit_s;
            scan_idx   <= idx_s;
            frame_done <= frame_done_s;
            load_ready <= ready_s;
        end
    end

endmodule
